// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Signal bundle between the 5-stage pipeline datapath and the
//               hazard/latch-enable sequencer.
//               master : the sequencer (reads hazard status, drives enables)
//               slave  : the pipeline datapath (drives status, reads enables)
//   Status  (pipeline -> sequencer):
//     ihit, dhit, mem_dreq, ex_memread, ex_rd, id_rs, id_rt, id_uses_rt,
//     id_branch, branch_taken, id_jump, wb_halt
//   Control (sequencer -> pipeline):
//     pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
//     halt, stall_cycles
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int REGW = 5,
    parameter int CNTW = 32
);
    // Pipeline status
    logic            ihit;
    logic            dhit;
    logic            mem_dreq;
    logic            ex_memread;
    logic [REGW-1:0] ex_rd;
    logic [REGW-1:0] id_rs;
    logic [REGW-1:0] id_rt;
    logic            id_uses_rt;
    logic            id_branch;
    logic            branch_taken;
    logic            id_jump;
    logic            wb_halt;

    // Latch controls
    logic            pc_en;
    logic            ifid_en;
    logic            idex_en;
    logic            exmem_en;
    logic            memwb_en;
    logic            ifid_flush;
    logic            idex_flush;
    logic            halt;
    logic [CNTW-1:0] stall_cycles;

    modport master (
        input  ihit, dhit, mem_dreq, ex_memread, ex_rd, id_rs, id_rt,
               id_uses_rt, id_branch, branch_taken, id_jump, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, halt, stall_cycles
    );

    modport slave (
        output ihit, dhit, mem_dreq, ex_memread, ex_rd, id_rs, id_rt,
               id_uses_rt, id_branch, branch_taken, id_jump, wb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, halt, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Latch-enable / flush sequencer for a 5-stage pipeline.
//               Detects load-use and load-to-branch hazards, freezes the
//               pipeline on data-memory wait, bubbles IF/ID on instruction
//               miss, squashes the fetch slot on taken branches/jumps and
//               parks the core once a halt reaches WB.
// Ports       : clk, rst (async, active-high)
//               bus : pipeline_hazard_ctrl_if.master (status in, controls out)
// Parameters  : REGW - register-index width, CNTW - stall-counter width
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REGW = 5,
    parameter int CNTW = 32
) (
    input wire                     clk,
    input wire                     rst,
    pipeline_hazard_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_LU_BR  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] c_cnt_max = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] c_cnt_one = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [REGW-1:0] c_reg_zero = {REGW{1'b0}};

    state_t          r_state;
    state_t          w_next_state;
    logic            r_halt;
    logic [CNTW-1:0] r_stall_cycles;

    logic [REGW-1:0] w_ex_rd;
    logic [REGW-1:0] w_id_rs;
    logic [REGW-1:0] w_id_rt;
    logic            w_hz;
    logic            w_dwait;

    logic            w_pc_en;
    logic            w_ifid_en;
    logic            w_idex_en;
    logic            w_exmem_en;
    logic            w_memwb_en;
    logic            w_ifid_flush;
    logic            w_idex_flush;

    assign w_ex_rd = bus.ex_rd;
    assign w_id_rs = bus.id_rs;
    assign w_id_rt = bus.id_rt;

    // A load in EX whose result the ID instruction needs right now; $0 is
    // never a real dependency because it always reads as zero.
    assign w_hz = bus.ex_memread && (w_ex_rd != c_reg_zero) &&
                  ((w_ex_rd == w_id_rs) ||
                   (bus.id_uses_rt && (w_ex_rd == w_id_rt)));

    assign w_dwait = bus.mem_dreq && !bus.dhit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and latch controls
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_pc_en      = 1'b0;
        w_ifid_en    = 1'b0;
        w_idex_en    = 1'b0;
        w_exmem_en   = 1'b0;
        w_memwb_en   = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;

        case (r_state)
            S_RUN, S_LU_BR: begin
                if (bus.wb_halt) begin
                    w_next_state = S_HALTED;
                end else if (w_dwait) begin
                    // Full freeze: state held, so a pending LU_BR survives.
                    w_next_state = r_state;
                end else if (r_state == S_LU_BR) begin
                    // Second bubble of load-to-branch.
                    w_idex_en    = 1'b1;
                    w_idex_flush = 1'b1;
                    w_exmem_en   = 1'b1;
                    w_memwb_en   = 1'b1;
                    w_next_state = S_RUN;
                end else if (w_hz) begin
                    // Branches resolve in ID, so they need the loaded value
                    // one stage earlier than ALU ops: two bubbles instead
                    // of one.
                    w_idex_en    = 1'b1;
                    w_idex_flush = 1'b1;
                    w_exmem_en   = 1'b1;
                    w_memwb_en   = 1'b1;
                    w_next_state = bus.id_branch ? S_LU_BR : S_RUN;
                end else if (!bus.ihit) begin
                    // No valid fetch word: hold PC, feed IF/ID a bubble. A
                    // simultaneous taken branch is squashed implicitly.
                    w_ifid_en    = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_idex_en    = 1'b1;
                    w_exmem_en   = 1'b1;
                    w_memwb_en   = 1'b1;
                end else if ((bus.id_branch && bus.branch_taken) ||
                             bus.id_jump) begin
                    w_pc_en      = 1'b1;
                    w_ifid_en    = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_idex_en    = 1'b1;
                    w_exmem_en   = 1'b1;
                    w_memwb_en   = 1'b1;
                end else begin
                    w_pc_en      = 1'b1;
                    w_ifid_en    = 1'b1;
                    w_idex_en    = 1'b1;
                    w_exmem_en   = 1'b1;
                    w_memwb_en   = 1'b1;
                end
            end
            S_HALTED: begin
                w_next_state = S_HALTED;
            end
            default: begin
                // Unreachable encoding: recover to RUN with everything held.
                w_next_state = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky halt flag and saturating stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halt <= 1'b0;
        end else begin
            r_halt <= (w_next_state == S_HALTED);
        end
    end

    // The cycle that samples wb_halt is still counted (state is not yet
    // HALTED); once parked the counter is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= {CNTW{1'b0}};
        end else if ((r_state != S_HALTED) && !w_pc_en &&
                     (r_stall_cycles != c_cnt_max)) begin
            r_stall_cycles <= r_stall_cycles + c_cnt_one;
        end
    end

    assign bus.pc_en        = w_pc_en;
    assign bus.ifid_en      = w_ifid_en;
    assign bus.idex_en      = w_idex_en;
    assign bus.exmem_en     = w_exmem_en;
    assign bus.memwb_en     = w_memwb_en;
    assign bus.ifid_flush   = w_ifid_flush;
    assign bus.idex_flush   = w_idex_flush;
    assign bus.halt         = r_halt;
    assign bus.stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed, self-checking bench for pipeline_hazard_ctrl.
//               Main instance uses default widths; a second instance with a
//               3-bit stall counter shares the stimulus to reach saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    // Control vector: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    localparam logic [6:0] c_all    = 7'b11111_00;
    localparam logic [6:0] c_freeze = 7'b00000_00;
    localparam logic [6:0] c_bub    = 7'b00111_01;
    localparam logic [6:0] c_imiss  = 7'b01111_10;
    localparam logic [6:0] c_sq     = 7'b11111_10;

    typedef struct {
        string       tag;
        logic [6:0]  code;
        logic        halt;
        logic [31:0] stall;
        bit          chk_sat;
        logic [2:0]  sat;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    exp_t sb[$];

    pipeline_hazard_ctrl_if #(.REGW(5), .CNTW(32)) bus ();
    pipeline_hazard_ctrl_if #(.REGW(5), .CNTW(3))  bus_s ();

    pipeline_hazard_ctrl #(.REGW(5), .CNTW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipeline_hazard_ctrl #(.REGW(5), .CNTW(3)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    assign bus_s.ihit         = bus.ihit;
    assign bus_s.dhit         = bus.dhit;
    assign bus_s.mem_dreq     = bus.mem_dreq;
    assign bus_s.ex_memread   = bus.ex_memread;
    assign bus_s.ex_rd        = bus.ex_rd;
    assign bus_s.id_rs        = bus.id_rs;
    assign bus_s.id_rt        = bus.id_rt;
    assign bus_s.id_uses_rt   = bus.id_uses_rt;
    assign bus_s.id_branch    = bus.id_branch;
    assign bus_s.branch_taken = bus.branch_taken;
    assign bus_s.id_jump      = bus.id_jump;
    assign bus_s.wb_halt      = bus.wb_halt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.ihit         = 1'b1;
        bus.dhit         = 1'b1;
        bus.mem_dreq     = 1'b0;
        bus.ex_memread   = 1'b0;
        bus.ex_rd        = 5'd0;
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.id_uses_rt   = 1'b0;
        bus.id_branch    = 1'b0;
        bus.branch_taken = 1'b0;
        bus.id_jump      = 1'b0;
        bus.wb_halt      = 1'b0;
    endtask

    task automatic load_hz(input logic [4:0] rd, input logic [4:0] rs,
                           input logic [4:0] rt, input logic uses_rt,
                           input logic br);
        bus.ex_memread = 1'b1;
        bus.ex_rd      = rd;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_uses_rt = uses_rt;
        bus.id_branch  = br;
    endtask

    // Queue the expectation for the inputs just driven, then sample the DUT
    // shortly after (well clear of the next rising edge) and score it.
    task automatic step(input string tag, input logic [6:0] code,
                        input logic h, input logic [31:0] s,
                        input bit chk_sat = 1'b0, input logic [2:0] sat = 3'd0);
        exp_t e;
        exp_t g;
        logic [6:0] obs;
        e.tag = tag; e.code = code; e.halt = h; e.stall = s;
        e.chk_sat = chk_sat; e.sat = sat;
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        obs = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
               bus.memwb_en, bus.ifid_flush, bus.idex_flush};
        n_cmp++;
        assert (obs === g.code) else begin
            n_fail++;
            $error("FAIL %s ctrl: got %b want %b", g.tag, obs, g.code);
        end
        n_cmp++;
        assert (bus.halt === g.halt) else begin
            n_fail++;
            $error("FAIL %s halt: got %b want %b", g.tag, bus.halt, g.halt);
        end
        n_cmp++;
        assert (bus.stall_cycles === g.stall) else begin
            n_fail++;
            $error("FAIL %s stall: got %0d want %0d", g.tag,
                   bus.stall_cycles, g.stall);
        end
        if (g.chk_sat) begin
            n_cmp++;
            assert (bus_s.stall_cycles === g.sat) else begin
                n_fail++;
                $error("FAIL %s sat_stall: got %0d want %0d", g.tag,
                       bus_s.stall_cycles, g.sat);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        idle();
        #2;
        step("reset", c_all, 1'b0, 32'd0, 1'b1, 3'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Plain run
        @(negedge clk); idle();
        step("idle", c_all, 1'b0, 32'd0);

        // lw $2 ; add $3,$2,$4 -> single bubble
        @(negedge clk); idle(); load_hz(5'd2, 5'd2, 5'd4, 1'b1, 1'b0);
        step("lu_rs", c_bub, 1'b0, 32'd0);
        @(negedge clk); idle();
        step("lu_after", c_all, 1'b0, 32'd1);

        // Dependency through rt
        @(negedge clk); idle(); load_hz(5'd7, 5'd1, 5'd7, 1'b1, 1'b0);
        step("lu_rt", c_bub, 1'b0, 32'd1);
        // rt matches but instruction doesn't read rt
        @(negedge clk); idle(); load_hz(5'd7, 5'd1, 5'd7, 1'b0, 1'b0);
        step("rt_unused", c_all, 1'b0, 32'd2);
        // lw $0 then use of $0
        @(negedge clk); idle(); load_hz(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        step("lw_r0", c_all, 1'b0, 32'd2);

        // lw $5 ; beq $5,$0 -> two bubbles
        @(negedge clk); idle(); load_hz(5'd5, 5'd5, 5'd0, 1'b1, 1'b1);
        step("lubr_1", c_bub, 1'b0, 32'd2);
        @(negedge clk); idle(); bus.id_branch = 1'b1;
        step("lubr_2", c_bub, 1'b0, 32'd3);
        @(negedge clk); idle(); bus.id_branch = 1'b1;
        step("lubr_done", c_all, 1'b0, 32'd4);

        // Taken branch and jump squash the fetch slot
        @(negedge clk); idle(); bus.id_branch = 1'b1; bus.branch_taken = 1'b1;
        step("br_taken", c_sq, 1'b0, 32'd4);
        @(negedge clk); idle(); bus.id_jump = 1'b1;
        step("jump", c_sq, 1'b0, 32'd4);

        // Data memory wait for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); bus.mem_dreq = 1'b1; bus.dhit = 1'b0;
            step($sformatf("dwait_%0d", i), c_freeze, 1'b0, 32'(4 + i));
        end
        @(negedge clk); idle(); bus.mem_dreq = 1'b1;
        step("dwait_done", c_all, 1'b0, 32'd7);

        // Instruction miss, alone and with a taken branch
        @(negedge clk); idle(); bus.ihit = 1'b0;
        step("imiss", c_imiss, 1'b0, 32'd7);
        @(negedge clk); idle(); bus.ihit = 1'b0;
        bus.id_branch = 1'b1; bus.branch_taken = 1'b1;
        step("imiss_br", c_imiss, 1'b0, 32'd8);

        // dwait and hz together: freeze wins, hz then re-evaluated
        @(negedge clk); idle(); load_hz(5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
        bus.mem_dreq = 1'b1; bus.dhit = 1'b0;
        step("dw_hz", c_freeze, 1'b0, 32'd9);
        @(negedge clk); idle(); load_hz(5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
        bus.mem_dreq = 1'b1;
        step("dw_hz_after", c_bub, 1'b0, 32'd10);

        // dwait during LU_BR extends the freeze; LU_BR still runs once
        @(negedge clk); idle(); load_hz(5'd6, 5'd6, 5'd0, 1'b1, 1'b1);
        step("lubr_dw_1", c_bub, 1'b0, 32'd11);
        @(negedge clk); idle(); bus.id_branch = 1'b1;
        bus.mem_dreq = 1'b1; bus.dhit = 1'b0;
        step("lubr_dw_frz", c_freeze, 1'b0, 32'd12);
        @(negedge clk); idle(); bus.id_branch = 1'b1;
        step("lubr_dw_2", c_bub, 1'b0, 32'd13);
        @(negedge clk); idle(); bus.id_branch = 1'b1;
        step("lubr_dw_done", c_all, 1'b0, 32'd14);

        // Reset in the middle of LU_BR leaves nothing pending
        @(negedge clk); idle(); load_hz(5'd6, 5'd6, 5'd0, 1'b1, 1'b1);
        step("lubr_rst_1", c_bub, 1'b0, 32'd14);
        @(negedge clk); idle(); bus.id_branch = 1'b1; rst = 1'b1;
        step("rst_async", c_all, 1'b0, 32'd0);
        @(negedge clk); rst = 1'b0; idle(); bus.id_branch = 1'b1;
        step("rst_no_pend", c_all, 1'b0, 32'd0);

        // Halt: freeze that cycle, sticky halt after, counter frozen
        @(negedge clk); idle(); bus.wb_halt = 1'b1;
        step("halt_smp", c_freeze, 1'b0, 32'd0);
        @(negedge clk); idle();
        step("halted_1", c_freeze, 1'b1, 32'd1);
        @(negedge clk); idle(); bus.ihit = 1'b0; bus.id_jump = 1'b1;
        step("halted_2", c_freeze, 1'b1, 32'd1);
        @(negedge clk); idle(); rst = 1'b1;
        step("halt_rst", c_all, 1'b0, 32'd0, 1'b1, 3'd0);
        @(negedge clk); rst = 1'b0;

        // Saturation on the 3-bit counter instance
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); idle(); bus.ihit = 1'b0;
            step($sformatf("sat_%0d", i), c_imiss, 1'b0, 32'(i), 1'b1,
                 (i > 7) ? 3'd7 : 3'(i));
        end
        @(negedge clk); idle(); bus.wb_halt = 1'b1;
        step("sat_halt", c_freeze, 1'b0, 32'd9, 1'b1, 3'd7);
        @(negedge clk); idle();
        step("sat_hold", c_freeze, 1'b1, 32'd10, 1'b1, 3'd7);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
